seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_scan_ctrl_hex7seg.sv | 13 +
 rtl/seg_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan controller.
//   state_e  : scan FSM states (OFF, BLANK, ON)
//   disp_t   : one captured display image (digits, decimal points, blank mask)
//   SEG_LUT  : active-low {g,f,e,d,c,b,a} pattern per hex nibble
//   SEG_OFF / AN_OFF : all-dark segment and anode values
package seg_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_e;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Entry [n] is the pattern for nibble n (index 15 listed first).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// hex7seg: combinational nibble-to-segment decode.
//   nib   in  4  hex value
//   seg_c out 7  active-low {g,f,e,d,c,b,a}
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_c
);

    assign seg_c = SEG_LUT[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 4-digit seven-segment driver with
// anti-ghost dead time per slot and frame-synchronous double-buffered load.
//   clk, rst_n          clock, async active-low reset
//   en, load            scan enable, capture request
//   digits/dp_in/blank_in  display image to capture
//   an, seg, dp         active-low display drive (registered)
//   digit_sel           index of the digit being driven (registered)
//   frame_done          one-cycle pulse at each frame wrap
// Optional feature: define LEADING_ZERO_SUPPRESS_EN to darken leading zeros.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 17,
    parameter int unsigned BLANK_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);

    localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYC - 1);

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    disp_t                act_q, act_d;
    disp_t                pend_q, pend_d;
    logic                 pend_v_q, pend_v_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [1:0]           sel_q, sel_d;
    logic                 fd_q, fd_d;

    disp_t      load_val_c;
    logic       tick_c, wrap_c, blank_c;
    logic [3:0] nib_c, lz_c;
    logic [6:0] dec_c;

    assign load_val_c = '{digits: digits, dp: dp_in, blank: blank_in};
    assign tick_c     = (state_q != ST_OFF) && (cnt_q == '1);
    assign wrap_c     = tick_c && (idx_q == 2'd3);
    assign nib_c      = 4'(act_q.digits >> {idx_q, 2'b00});

    // Leading-zero mask: digit i dark when nibbles i..3 are all zero.
`ifdef LEADING_ZERO_SUPPRESS_EN
    always_comb begin
        lz_c    = 4'b0000;
        lz_c[3] = (act_q.digits[15:12] == 4'h0);
        lz_c[2] = lz_c[3] && (act_q.digits[11:8] == 4'h0);
        lz_c[1] = lz_c[2] && (act_q.digits[7:4] == 4'h0);
    end
`else
    assign lz_c = 4'b0000;
`endif

    assign blank_c = act_q.blank[idx_q] | lz_c[idx_q];

    hex7seg u_hex7seg (
        .nib   (nib_c),
        .seg_c (dec_c)
    );

    // Scan FSM, refresh counter and digit index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_BLANK;
                ST_BLANK: begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                    if (cnt_q == BLANK_LAST) state_d = ST_ON;
                end
                ST_ON: begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                    if (tick_c) begin
                        state_d = ST_BLANK;
                        idx_d   = idx_q + 2'd1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Double buffer: direct write while OFF, otherwise swap only at frame wrap.
    always_comb begin
        act_d    = act_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (state_q == ST_OFF) begin
            if (load) begin
                act_d    = load_val_c;
                pend_v_d = 1'b0;
            end
        end else if (wrap_c) begin
            if (pend_v_q) act_d = pend_q;
            if (load)     pend_d = load_val_c;
            pend_v_d = load;
        end else if (load) begin
            pend_d   = load_val_c;
            pend_v_d = 1'b1;
        end
    end

    // Display drive, one cycle behind state/idx.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        sel_d = idx_q;
        fd_d  = wrap_c;
        if (state_q == ST_ON) begin
            an_d = ~(4'b0001 << idx_q);
            if (!blank_c) begin
                seg_d = dec_c;
                dp_d  = ~act_q.dp[idx_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            act_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            sel_q    <= 2'd0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            sel_q    <= sel_d;
            fd_q     <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_sel  = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (DIV_WIDTH=4, BLANK_CYC=2).
// The reference model tracks elapsed cycles since enable and derives slot,
// digit and dead time arithmetically. Define LEADING_ZERO_SUPPRESS_EN for both
// bench and RTL to exercise zero suppression.
module tb_seg_scan_ctrl;

    localparam int unsigned DW    = 4;
    localparam int unsigned BC    = 2;
    localparam int          SLOT  = 16;
    localparam int          FRAME = 64;

    logic        clk = 1'b0;
    logic        rst_n, en, load;
    logic [15:0] digits;
    logic [3:0]  dp_in, blank_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIV_WIDTH(DW), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] sel;
        logic       fd;
    } obs_t;

    localparam obs_t DARK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, sel: 2'd0, fd: 1'b0};

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state
    bit          m_run;
    int          m_t;
    logic [15:0] a_dig, p_dig;
    logic [3:0]  a_dp, a_bl, p_dp, p_bl;
    bit          p_v;

    function automatic logic [6:0] hex_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        int   pos, ix;
        bit   dark;
        o = DARK;
        if (m_run) begin
            pos   = m_t % SLOT;
            ix    = m_t / SLOT;
            o.sel = 2'(ix);
            o.fd  = (pos == SLOT - 1) && (ix == 3);
            if (pos >= int'(BC)) begin
                o.an = 4'hF ^ (4'(1) << ix);
                dark = a_bl[ix];
`ifdef LEADING_ZERO_SUPPRESS_EN
                if (ix > 0 && (a_dig >> (4 * ix)) == 16'h0) dark = 1'b1;
`endif
                if (!dark) begin
                    o.seg = hex_ref(4'(a_dig >> (4 * ix)));
                    o.dp  = ~a_dp[ix];
                end
            end
        end
        return o;
    endfunction

    function automatic obs_t cur();
        return {an, seg, dp, digit_sel, frame_done};
    endfunction

    function automatic void chk(input string nm, input obs_t g, input obs_t e);
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got an=%b seg=%b dp=%b sel=%0d fd=%b, expected an=%b seg=%b dp=%b sel=%0d fd=%b",
                     nm, $time, g.an, g.seg, g.dp, g.sel, g.fd, e.an, e.seg, e.dp, e.sel, e.fd);
        end
    endfunction

    function automatic void model_reset();
        m_run = 1'b0; m_t = 0; p_v = 1'b0;
        a_dig = '0; a_dp = '0; a_bl = '0;
        p_dig = '0; p_dp = '0; p_bl = '0;
    endfunction

    // Drive one cycle, queue the output expected after the coming edge, advance model.
    task automatic step(input bit e, input bit l, input logic [15:0] d,
                        input logic [3:0] p, input logic [3:0] b);
        bit wrap;
        @(negedge clk);
        en = e; load = l; digits = d; dp_in = p; blank_in = b;
        exp_q.push_back(model_out());
        wrap = m_run && (m_t == FRAME - 1);
        if (!m_run) begin
            if (l) begin a_dig = d; a_dp = p; a_bl = b; p_v = 1'b0; end
        end else if (wrap) begin
            if (p_v) begin a_dig = p_dig; a_dp = p_dp; a_bl = p_bl; end
            if (l)   begin p_dig = d; p_dp = p; p_bl = b; end
            p_v = l;
        end else if (l) begin
            p_dig = d; p_dp = p; p_bl = b; p_v = 1'b1;
        end
        if (!e)          begin m_run = 1'b0; m_t = 0; end
        else if (!m_run) begin m_run = 1'b1; m_t = 0; end
        else             m_t = (m_t + 1) % FRAME;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, digits, dp_in, blank_in);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_async", cur(), DARK);
        model_reset();
        en = 1'b0; load = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hold", cur(), DARK);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every cycle for which the driver queued an expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) chk("scan", cur(), exp_q.pop_front());
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        digits = '0; dp_in = '0; blank_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_values", cur(), DARK);
        rst_n = 1'b1;

        // Basic scan of 1234
        step(1'b1, 1'b1, 16'h1234, 4'b0010, 4'b0000);
        idle(FRAME * 2);

        // Mid-frame load: shown only after the wrap
        idle(20);
        step(1'b1, 1'b1, 16'hABCD, 4'b0101, 4'b0000);
        idle(FRAME * 2);

        // Pending load, then a second load exactly at the wrap
        idle(10);
        step(1'b1, 1'b1, 16'h9999, 4'b0000, 4'b0000);
        for (int i = 0; i < FRAME * 2 && !(m_run && m_t == FRAME - 1); i++) idle(1);
        step(1'b1, 1'b1, 16'h5678, 4'b1000, 4'b0000);
        idle(FRAME * 2 + 5);

        // Disable mid-slot, then restart
        idle(23);
        repeat (3) step(1'b0, 1'b0, digits, dp_in, blank_in);
        idle(FRAME + 8);

        // Reset mid-ON with a pending load outstanding
        step(1'b1, 1'b1, 16'hFFFF, 4'b1111, 4'b0000);
        for (int i = 0; i < FRAME && !(m_run && (m_t % SLOT) >= 5 && m_t < FRAME - 8); i++) idle(1);
        do_reset();
        idle(FRAME * 2);

        // Leading zeros and forced blank of digit 0
        step(1'b0, 1'b1, 16'h0050, 4'b0000, 4'b0000);
        idle(FRAME + 2);
        step(1'b1, 1'b1, 16'h0050, 4'b0000, 4'b0001);
        idle(FRAME * 2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 24) == 0),
                 16'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end
        idle(2);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
